// File: rtl/insn_bus_if_pkg.sv
// Shared cpu/bus definitions: fetch-master state encodings, NOP word,
// enable/reset polarities and default bus widths.
package insn_bus_if_pkg;

    localparam int ADDR_W_DEF = 30;
    localparam int DATA_W_DEF = 32;

    localparam logic ENABLE       = 1'b1;
    localparam logic DISABLE      = 1'b0;
    localparam logic RESET_ENABLE = 1'b1;

    localparam logic [31:0] ISA_NOP = 32'h0000_0000;

    typedef enum logic [2:0] {
        BUS_IF_STATE_IDLE   = 3'd0,
        BUS_IF_STATE_REQ    = 3'd1,
        BUS_IF_STATE_ACCESS = 3'd2,
        BUS_IF_STATE_HOLD   = 3'd3,
        BUS_IF_STATE_DRAIN  = 3'd4
    } bus_if_state_t;

endpackage

// File: rtl/insn_bus_if.sv
// Instruction-side bus master feeding the IF register; stalls fetch via busy.
// Define INSN_BUF_EN to add a one-entry last-word buffer that skips the bus on a hit.
//
// state  | meaning
// IDLE   | no transaction; accepts a new fetch (or serves a buffer hit)
// REQ    | bus_req raised, waiting for grant
// ACCESS | address strobe out, waiting for slave ready
// HOLD   | word arrived under stall; presented from hold_buf
// DRAIN  | fetch flushed mid-access; waiting out the bus cycle, data dropped
module insn_bus_if
    import insn_bus_if_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic              en,
    input  logic              stall,
    input  logic              flush,
    output logic [DATA_W-1:0] insn,
    output logic              busy,
    output logic              bus_req,
    input  logic              bus_grnt,
    output logic              bus_as,
    output logic [ADDR_W-1:0] bus_addr,
    input  logic              bus_rdy,
    input  logic [DATA_W-1:0] bus_rd_data
);

    localparam logic [DATA_W-1:0] NOP = DATA_W'(ISA_NOP);

    bus_if_state_t     state, state_nxt;
    logic              bus_req_nxt, bus_as_nxt;
    logic [ADDR_W-1:0] bus_addr_nxt;
    logic [DATA_W-1:0] hold_buf, hold_buf_nxt;
    logic              buf_hit;
    logic              access_done;

    assign access_done = (state == BUS_IF_STATE_ACCESS) && bus_rdy && !flush;

`ifdef INSN_BUF_EN
    logic              buf_valid;
    logic [ADDR_W-1:0] buf_addr;
    logic [DATA_W-1:0] buf_data;

    assign buf_hit = buf_valid && (addr == buf_addr);

    // Flush leaves the buffer alone; drained words never reach access_done.
    always_ff @(posedge clk) begin
        if (reset == RESET_ENABLE) begin
            buf_valid <= DISABLE;
            buf_addr  <= '0;
            buf_data  <= NOP;
        end else if (access_done) begin
            buf_valid <= ENABLE;
            buf_addr  <= bus_addr;
            buf_data  <= bus_rd_data;
        end
    end
`else
    assign buf_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset == RESET_ENABLE) begin
            state    <= BUS_IF_STATE_IDLE;
            bus_req  <= DISABLE;
            bus_as   <= DISABLE;
            bus_addr <= '0;
            hold_buf <= NOP;
        end else begin
            state    <= state_nxt;
            bus_req  <= bus_req_nxt;
            bus_as   <= bus_as_nxt;
            bus_addr <= bus_addr_nxt;
            hold_buf <= hold_buf_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        bus_req_nxt  = bus_req;
        bus_as_nxt   = bus_as;
        bus_addr_nxt = bus_addr;
        hold_buf_nxt = hold_buf;
        case (state)
            BUS_IF_STATE_IDLE: begin
                if (en && !flush && !buf_hit) begin
                    bus_req_nxt = ENABLE;
                    state_nxt   = BUS_IF_STATE_REQ;
                end
            end
            BUS_IF_STATE_REQ: begin
                if (flush) begin
                    bus_req_nxt = DISABLE;
                    state_nxt   = BUS_IF_STATE_IDLE;
                end else if (bus_grnt) begin
                    bus_as_nxt   = ENABLE;
                    bus_addr_nxt = addr;
                    state_nxt    = BUS_IF_STATE_ACCESS;
                end
            end
            BUS_IF_STATE_ACCESS: begin
                // The bus cannot abort, so a flush without ready has to drain.
                if (bus_rdy) begin
                    bus_as_nxt  = DISABLE;
                    bus_req_nxt = DISABLE;
                    if (!flush && stall) begin
                        hold_buf_nxt = bus_rd_data;
                        state_nxt    = BUS_IF_STATE_HOLD;
                    end else begin
                        state_nxt = BUS_IF_STATE_IDLE;
                    end
                end else if (flush) begin
                    state_nxt = BUS_IF_STATE_DRAIN;
                end
            end
            BUS_IF_STATE_HOLD: begin
                if (flush) begin
                    hold_buf_nxt = NOP;
                    state_nxt    = BUS_IF_STATE_IDLE;
                end else if (!stall) begin
                    state_nxt = BUS_IF_STATE_IDLE;
                end
            end
            BUS_IF_STATE_DRAIN: begin
                if (bus_rdy) begin
                    bus_as_nxt  = DISABLE;
                    bus_req_nxt = DISABLE;
                    state_nxt   = BUS_IF_STATE_IDLE;
                end
            end
            default: begin
                bus_as_nxt  = DISABLE;
                bus_req_nxt = DISABLE;
                state_nxt   = BUS_IF_STATE_IDLE;
            end
        endcase
    end

    always_comb begin
        busy = DISABLE;
        insn = NOP;
        if (reset != RESET_ENABLE) begin
            case (state)
                BUS_IF_STATE_IDLE: begin
                    if (en && !flush) begin
`ifdef INSN_BUF_EN
                        if (buf_hit) insn = buf_data;
`endif
                        busy = !buf_hit;
                    end
                end
                BUS_IF_STATE_REQ: busy = !flush;
                BUS_IF_STATE_ACCESS: begin
                    if (!flush) begin
                        if (bus_rdy) insn = bus_rd_data;
                        else         busy = ENABLE;
                    end
                end
                BUS_IF_STATE_HOLD: begin
                    if (!flush) insn = hold_buf;
                end
                BUS_IF_STATE_DRAIN: busy = en;
                default: busy = DISABLE;
            endcase
        end
    end

endmodule

// File: tb/tb_insn_bus_if.sv
// Directed self-checking bench for insn_bus_if; covers INSN_BUF_EN when defined.
module tb_insn_bus_if;
    import insn_bus_if_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [29:0] addr;
    logic        en, stall, flush;
    logic [31:0] insn;
    logic        busy, bus_req, bus_grnt, bus_as, bus_rdy;
    logic [29:0] bus_addr;
    logic [31:0] bus_rd_data;

    int n_assert = 0;
    int n_fail   = 0;
    int busy_cnt;
    logic addr_bad;

    always #5 clk = ~clk;

    insn_bus_if #(.ADDR_W(30), .DATA_W(32)) dut (
        .clk(clk), .reset(reset), .addr(addr), .en(en), .stall(stall),
        .flush(flush), .insn(insn), .busy(busy), .bus_req(bus_req),
        .bus_grnt(bus_grnt), .bus_as(bus_as), .bus_addr(bus_addr),
        .bus_rdy(bus_rdy), .bus_rd_data(bus_rd_data)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1; addr = '0; en = 0; stall = 0; flush = 0;
        bus_grnt = 0; bus_rdy = 0; bus_rd_data = '0;
        tick(); tick();
        chk("rst_req", 32'(bus_req), 0);
        chk("rst_as", 32'(bus_as), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_insn", insn, ISA_NOP);
        reset = 0;
        tick();

        // minimal 3-cycle fetch
        addr = 30'h10; en = 1; bus_grnt = 1; bus_rd_data = 32'h1234_5678; #1;
        chk("f1_idle_busy", 32'(busy), 1);
        chk("f1_idle_insn", insn, ISA_NOP);
        tick();
        chk("f1_req", 32'(bus_req), 1);
        chk("f1_req_busy", 32'(busy), 1);
        tick();
        en = 0; bus_rdy = 1; #1;
        chk("f1_as", 32'(bus_as), 1);
        chk("f1_addr", 32'(bus_addr), 32'h10);
        chk("f1_insn", insn, 32'h1234_5678);
        chk("f1_busy", 32'(busy), 0);
        tick();
        bus_rdy = 0; bus_grnt = 0; #1;
        chk("f1_end_as", 32'(bus_as), 0);
        chk("f1_end_req", 32'(bus_req), 0);
        chk("f1_end_insn", insn, ISA_NOP);

        // grant on 4th REQ cycle, ready on 3rd ACCESS cycle
        busy_cnt = 0; addr_bad = 0;
        for (int c = 0; c < 8; c++) begin
            en = (c == 0); bus_grnt = (c == 4); bus_rdy = (c == 7);
            bus_rd_data = 32'hA5A5_0001;
            addr = (c >= 5) ? 30'h77 : 30'h55;
            #1;
            if (busy) busy_cnt++;
            if (c >= 5 && bus_addr !== 30'h55) addr_bad = 1;
            if (c == 7) chk("f2_insn", insn, 32'hA5A5_0001);
            tick();
        end
        bus_grnt = 0; bus_rdy = 0; #1;
        chk("f2_busy_cycles", busy_cnt, 7);
        chk("f2_addr_stable", 32'(addr_bad), 0);
        chk("f2_end_req", 32'(bus_req), 0);

        // ready under stall -> HOLD
        addr = 30'h30; en = 1; bus_grnt = 1; tick();
        en = 0; tick();
        bus_rdy = 1; stall = 1; bus_rd_data = 32'hDEAD_BEEF; #1;
        chk("st_rdy_busy", 32'(busy), 0);
        tick();
        bus_rdy = 0; bus_grnt = 0; bus_rd_data = 32'h1111_1111; #1;
        chk("st_hold_insn", insn, 32'hDEAD_BEEF);
        chk("st_hold_as", 32'(bus_as), 0);
        chk("st_hold_req", 32'(bus_req), 0);
        tick();
        chk("st_hold2_insn", insn, 32'hDEAD_BEEF);
        stall = 0; #1;
        chk("st_release_insn", insn, 32'hDEAD_BEEF);
        tick();
        chk("st_idle_insn", insn, ISA_NOP);

        // flush in ACCESS, ready 3 cycles later
        addr = 30'h40; en = 1; bus_grnt = 1; tick();
        en = 0; tick();
        flush = 1; bus_rd_data = 32'hCAFE_F00D; #1;
        chk("fl_busy", 32'(busy), 0);
        chk("fl_insn", insn, ISA_NOP);
        tick();
        flush = 0; bus_grnt = 0; #1;
        chk("fl_drain_as", 32'(bus_as), 1);
        chk("fl_drain_insn", insn, ISA_NOP);
        chk("fl_drain_busy0", 32'(busy), 0);
        tick();
        en = 1; #1;
        chk("fl_drain_busy_en", 32'(busy), 1);
        tick();
        en = 0; bus_rdy = 1; #1;
        chk("fl_rdy_insn", insn, ISA_NOP);
        chk("fl_rdy_as", 32'(bus_as), 1);
        tick();
        bus_rdy = 0; #1;
        chk("fl_end_as", 32'(bus_as), 0);
        chk("fl_end_req", 32'(bus_req), 0);

        // flush while waiting for grant
        en = 1; tick();
        en = 0; flush = 1; #1;
        chk("flreq_busy", 32'(busy), 0);
        tick();
        flush = 0; #1;
        chk("flreq_req", 32'(bus_req), 0);

        // flush together with stall in HOLD: flush wins
        addr = 30'h31; en = 1; bus_grnt = 1; tick();
        en = 0; tick();
        bus_rdy = 1; stall = 1; bus_rd_data = 32'h5555_AAAA; tick();
        bus_rdy = 0; bus_grnt = 0; flush = 1; #1;
        chk("fs_insn", insn, ISA_NOP);
        tick();
        flush = 0; #1;
        chk("fs_idle_insn", insn, ISA_NOP);
        stall = 0;

        // reset mid-transaction
        addr = 30'h50; en = 1; bus_grnt = 1; tick();
        en = 0; tick();
        chk("rm_as_before", 32'(bus_as), 1);
        reset = 1; tick();
        chk("rm_as", 32'(bus_as), 0);
        chk("rm_req", 32'(bus_req), 0);
        reset = 0; bus_grnt = 0; tick();

`ifdef INSN_BUF_EN
        addr = 30'h20; en = 1; bus_grnt = 1; tick();
        en = 0; tick();
        bus_rdy = 1; bus_rd_data = 32'hB0B0_2020; tick();
        bus_rdy = 0; bus_rd_data = 32'h0; en = 1; #1;
        chk("bf_hit_busy", 32'(busy), 0);
        chk("bf_hit_insn", insn, 32'hB0B0_2020);
        tick();
        chk("bf_hit_req", 32'(bus_req), 0);
        addr = 30'h21; #1;
        chk("bf_miss_busy", 32'(busy), 1);
        tick();
        en = 0;
        chk("bf_miss_req", 32'(bus_req), 1);
        tick();
        bus_rdy = 1; bus_rd_data = 32'hB0B0_2121; #1;
        chk("bf_miss_insn", insn, 32'hB0B0_2121);
        tick();
        bus_rdy = 0; bus_grnt = 0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
